// File: rtl/adc_sched_pkg.sv
// rtl/adc_sched_pkg.sv - shared state encoding, tag layout and word builder for the capture scheduler
package adc_sched_pkg;

    localparam int SAMPLE_W   = 12;
    localparam int WORD_W     = 16;

    localparam int SOF_BIT    = 15;
    localparam int EOF_BIT    = 14;
    localparam int FORCED_BIT = 13;
    localparam int OVF_BIT    = 12;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_t;

    function automatic logic [WORD_W-1:0] make_word(
        input logic                sof,
        input logic                eof,
        input logic                forced,
        input logic                ovf,
        input logic [SAMPLE_W-1:0] sample
    );
        logic [WORD_W-1:0] w;
        w                 = '0;
        w[SOF_BIT]        = sof;
        w[EOF_BIT]        = eof;
        w[FORCED_BIT]     = forced;
        w[OVF_BIT]        = ovf;
        w[SAMPLE_W-1:0]   = sample;
        return w;
    endfunction

endpackage

// File: rtl/adc_tick_gen.sv
// rtl/adc_tick_gen.sv - decimation counter producing one tick every div_sel+1 cycles
//
// Ports:
//   clk50m   system clock
//   reset_n  asynchronous active-low reset
//   clear    restart the count at 0 on the next cycle
//   div_sel  terminal count; tick when count == div_sel
//   tick     combinational, high on the terminal-count cycle
module adc_tick_gen (
    input  logic        clk50m,
    input  logic        reset_n,
    input  logic        clear,
    input  logic [15:0] div_sel,
    output logic        tick
);

    logic [15:0] cnt;

    assign tick = (cnt == div_sel);

    always_ff @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/adc_capture_sched.sv
// rtl/adc_capture_sched.sv - triggered fixed-length frame capture from the ADC into the sample FIFO
//
// Ports:
//   clk50m, reset_n        clock, asynchronous active-low reset
//   ad_ch1                 12-bit sample, valid every cycle
//   start, stop            one-cycle pulses: begin capture / abort to IDLE
//   cont, trig_mode,
//   trig_level, div_sel    configuration, latched on an accepted start
//   fifo_full, fifo_empty  FIFO status
//   wr_en, wr_data         FIFO write strobe and tagged word {SOF,EOF,forced,ovf,sample}
//   busy, overflow,
//   frame_cnt, state_o     status
module adc_capture_sched
    import adc_sched_pkg::*;
#(
    parameter int FRAME_LEN   = 256,
    parameter int ARM_TIMEOUT = 65535,
    parameter int HOLDOFF_CYC = 1000
) (
    input  logic        clk50m,
    input  logic        reset_n,
    input  logic [11:0] ad_ch1,
    input  logic        start,
    input  logic        stop,
    input  logic        cont,
    input  logic        trig_mode,
    input  logic [11:0] trig_level,
    input  logic [15:0] div_sel,
    input  logic        fifo_full,
    input  logic        fifo_empty,
    output logic        wr_en,
    output logic [15:0] wr_data,
    output logic        busy,
    output logic        overflow,
    output logic [7:0]  frame_cnt,
    output logic [2:0]  state_o
);

    localparam int TO_W = $clog2(ARM_TIMEOUT + 1);
    localparam int HO_W = $clog2(HOLDOFF_CYC + 1);
    localparam logic [15:0] LAST_SMP = 16'(FRAME_LEN - 1);

    state_t state, state_nx;

    logic            tick, tick_clr;
    logic [15:0]     div_l;
    logic            mode_l, cont_l;
    logic [11:0]     level_l;
    logic [11:0]     prev;
    logic            prev_valid;
    logic [TO_W-1:0] to_cnt;
    logic [15:0]     smp_n;
    logic [HO_W-1:0] hold_cnt;
    logic            forced_l;

    logic start_ok, edge_hit, timeout_hit, last_smp, hold_done;
    logic trig, trig_forced, emit, do_write, do_drop;
    logic word_sof, word_eof, word_forced;

    adc_tick_gen u_tick (
        .clk50m  (clk50m),
        .reset_n (reset_n),
        .clear   (tick_clr),
        .div_sel (div_l),
        .tick    (tick)
    );

    always_ff @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        start_ok    = 1'b0;
        trig        = 1'b0;
        trig_forced = 1'b0;
        emit        = 1'b0;
        // The first ARM tick only loads prev, so prev_valid gates the edge detector.
        edge_hit    = prev_valid && (prev < level_l) && (ad_ch1 >= level_l);
        timeout_hit = (to_cnt == TO_W'(ARM_TIMEOUT));
        last_smp    = (smp_n == LAST_SMP);
        hold_done   = (hold_cnt == HO_W'(HOLDOFF_CYC - 1));

        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    start_ok = 1'b1;
                    state_nx = ST_ARM;
                end
            end
            ST_ARM: begin
                if (tick) begin
                    if (!mode_l || edge_hit) begin
                        trig = 1'b1;
                    end else if (timeout_hit) begin
                        trig        = 1'b1;
                        trig_forced = 1'b1;
                    end
                    if (trig) begin
                        emit     = 1'b1;
                        state_nx = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (tick) begin
                    emit = 1'b1;
                    if (last_smp) begin
                        state_nx = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_nx = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (hold_done) begin
                    state_nx = cont_l ? ST_ARM : ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // Abort wins over everything, including a trigger in the same cycle.
        if (stop && (state != ST_IDLE)) begin
            state_nx    = ST_IDLE;
            emit        = 1'b0;
            trig        = 1'b0;
            trig_forced = 1'b0;
        end

        do_write    = emit && !fifo_full;
        do_drop     = emit && fifo_full;
        tick_clr    = (state_nx == ST_ARM) && (state != ST_ARM);
        word_sof    = (state == ST_ARM);
        word_eof    = (state == ST_CAPTURE) && last_smp;
        word_forced = (state == ST_ARM) ? trig_forced : forced_l;
    end

    always_ff @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) begin
            wr_en      <= 1'b0;
            wr_data    <= '0;
            overflow   <= 1'b0;
            frame_cnt  <= '0;
            div_l      <= '0;
            mode_l     <= 1'b0;
            cont_l     <= 1'b0;
            level_l    <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            to_cnt     <= '0;
            smp_n      <= '0;
            hold_cnt   <= '0;
            forced_l   <= 1'b0;
        end else begin
            wr_en <= do_write;
            if (do_write) begin
                wr_data <= make_word(word_sof, word_eof, word_forced, overflow, ad_ch1);
            end
            if (do_drop) begin
                overflow <= 1'b1;
            end

            if (start_ok) begin
                div_l   <= div_sel;
                mode_l  <= trig_mode;
                level_l <= trig_level;
                cont_l  <= cont;
            end

            // Every entry into ARM (from IDLE or a continuous re-arm) starts a fresh frame.
            if (tick_clr) begin
                overflow   <= 1'b0;
                smp_n      <= '0;
                to_cnt     <= '0;
                prev_valid <= 1'b0;
                forced_l   <= 1'b0;
            end else if ((state == ST_ARM) && tick) begin
                prev       <= ad_ch1;
                prev_valid <= 1'b1;
                if (trig) begin
                    // Triggering sample is sample 0 and has already been emitted.
                    smp_n    <= 16'd1;
                    forced_l <= trig_forced;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else if ((state == ST_CAPTURE) && tick) begin
                smp_n <= smp_n + 16'd1;
            end

            if ((state == ST_CAPTURE) && (state_nx == ST_DRAIN)) begin
                frame_cnt <= frame_cnt + 8'd1;
            end

            hold_cnt <= (state == ST_HOLDOFF) ? hold_cnt + 1'b1 : '0;
        end
    end

    assign busy    = (state != ST_IDLE);
    assign state_o = state;

endmodule

// File: tb/tb_adc_capture_sched.sv
// tb/tb_adc_capture_sched.sv - directed scoreboard bench for adc_capture_sched
module tb_adc_capture_sched;

    localparam int FL = 8;
    localparam int AT = 4;
    localparam int HC = 5;

    logic        clk50m = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] ad_ch1 = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        cont = 1'b0;
    logic        trig_mode = 1'b0;
    logic [11:0] trig_level = '0;
    logic [15:0] div_sel = '0;
    logic        fifo_full = 1'b0;
    logic        fifo_empty = 1'b0;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        busy;
    logic        overflow;
    logic [7:0]  frame_cnt;
    logic [2:0]  state_o;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  exp_fc = '0;

    adc_capture_sched #(
        .FRAME_LEN   (FL),
        .ARM_TIMEOUT (AT),
        .HOLDOFF_CYC (HC)
    ) dut (
        .clk50m     (clk50m),
        .reset_n    (reset_n),
        .ad_ch1     (ad_ch1),
        .start      (start),
        .stop       (stop),
        .cont       (cont),
        .trig_mode  (trig_mode),
        .trig_level (trig_level),
        .div_sel    (div_sel),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .busy       (busy),
        .overflow   (overflow),
        .frame_cnt  (frame_cnt),
        .state_o    (state_o)
    );

    always #5 clk50m = ~clk50m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk50m);
        #1;
    endtask

    // Every FIFO write is matched against the oldest expected word.
    always @(negedge clk50m) begin
        if (reset_n && wr_en) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 32'(wr_data), 32'h1_0000);
            end else begin
                chk("wr_data", 32'(wr_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400 && busy; i++) begin
            step();
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    // Entered in the ARM cycle with div_sel=0, trig_mode=0: one sample per cycle.
    task automatic run_frame(input logic [11:0] base, input int dlo, input int dhi, input bit chk_wr);
        logic dropped;
        logic [11:0] s;
        dropped = 1'b0;
        for (int k = 0; k < FL; k++) begin
            s = base + 12'(k);
            ad_ch1 = s;
            fifo_full = (k >= dlo) && (k <= dhi);
            if (!fifo_full) begin
                exp_q.push_back({(k == 0), (k == FL - 1), 1'b0, dropped, s});
            end else begin
                dropped = 1'b1;
            end
            if (chk_wr) chk("wr_pulse_train", 32'(wr_en), 32'(k != 0));
            step();
        end
        fifo_full = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_state", 32'(state_o), 32'd0);
        reset_n = 1'b1;
        step();

        // T1: immediate trigger, basic frame, DRAIN wait, HOLDOFF length
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_state_arm", 32'(state_o), 32'd1);
        run_frame(12'hA00, 99, 99, 1'b1);
        exp_fc = exp_fc + 8'd1;
        chk("t1_last_wr", 32'(wr_en), 32'd1);
        chk("t1_state_drain", 32'(state_o), 32'd3);
        chk("t1_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
        step();
        chk("t1_wr_after_eof", 32'(wr_en), 32'd0);
        repeat (3) step();
        chk("t1_drain_holds", 32'(state_o), 32'd3);
        fifo_empty = 1'b1;
        step();
        fifo_empty = 1'b0;
        chk("t1_state_holdoff", 32'(state_o), 32'd4);
        repeat (HC - 1) step();
        chk("t1_busy_holdoff_end", 32'(busy), 32'd1);
        step();
        chk("t1_busy_fall", 32'(busy), 32'd0);
        chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // T2: rising-edge trigger on a ramp
        trig_mode = 1'b1;
        trig_level = 12'h800;
        fifo_empty = 1'b1;
        ad_ch1 = 12'h7F0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < FL; k++) begin
            exp_q.push_back({(k == 0), (k == FL - 1), 2'b00, 12'h800 + 12'(2 * k)});
        end
        ad_ch1 = 12'h7FC;
        step();
        chk("t2_no_early_wr_a", 32'(wr_en), 32'd0);
        ad_ch1 = 12'h7FE;
        step();
        chk("t2_no_early_wr_b", 32'(wr_en), 32'd0);
        chk("t2_still_arm", 32'(state_o), 32'd1);
        ad_ch1 = 12'h800;
        step();
        chk("t2_state_capture", 32'(state_o), 32'd2);
        for (int k = 1; k < FL; k++) begin
            ad_ch1 = 12'h800 + 12'(2 * k);
            step();
        end
        wait_idle("t2_idle");
        exp_fc = exp_fc + 8'd1;
        chk("t2_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
        chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // T3: forced trigger after ARM_TIMEOUT ticks with decimation
        div_sel = 16'd3;
        ad_ch1 = 12'h100;
        for (int k = 0; k < FL; k++) begin
            exp_q.push_back({(k == 0), (k == FL - 1), 1'b1, 1'b0, 12'h100});
        end
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (19) step();
        chk("t3_arm_until_5th_tick", 32'(state_o), 32'd1);
        chk("t3_no_early_wr", 32'(wr_en), 32'd0);
        step();
        chk("t3_first_wr", 32'(wr_en), 32'd1);
        chk("t3_state_capture", 32'(state_o), 32'd2);
        step();
        chk("t3_single_pulse", 32'(wr_en), 32'd0);
        wait_idle("t3_idle");
        exp_fc = exp_fc + 8'd1;
        chk("t3_q_empty", 32'(exp_q.size()), 32'd0);

        // T4: FIFO full during samples 3..4
        trig_mode = 1'b0;
        div_sel = 16'd0;
        fifo_empty = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        run_frame(12'h300, 3, 4, 1'b0);
        exp_fc = exp_fc + 8'd1;
        chk("t4_overflow", 32'(overflow), 32'd1);
        chk("t4_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
        fifo_empty = 1'b1;
        wait_idle("t4_idle");
        fifo_empty = 1'b0;
        chk("t4_q_empty", 32'(exp_q.size()), 32'd0);

        // T6: stop during CAPTURE at sample 4
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t6_overflow_cleared", 32'(overflow), 32'd0);
        for (int k = 0; k < 4; k++) begin
            ad_ch1 = 12'h600 + 12'(k);
            exp_q.push_back({(k == 0), 1'b0, 2'b00, 12'h600 + 12'(k)});
            step();
        end
        ad_ch1 = 12'h604;
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t6_idle_next", 32'(state_o), 32'd0);
        chk("t6_wr_en_off", 32'(wr_en), 32'd0);
        repeat (10) step();
        chk("t6_frame_cnt_kept", 32'(frame_cnt), 32'(exp_fc));
        chk("t6_q_empty", 32'(exp_q.size()), 32'd0);

        // T7: asynchronous reset mid-frame
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ad_ch1 = 12'h700 + 12'(k);
            exp_q.push_back({(k == 0), 1'b0, 2'b00, 12'h700 + 12'(k)});
            step();
        end
        @(negedge clk50m);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t7_async_wr_en", 32'(wr_en), 32'd0);
        chk("t7_async_wr_data", 32'(wr_data), 32'd0);
        chk("t7_async_busy", 32'(busy), 32'd0);
        chk("t7_async_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("t7_async_state", 32'(state_o), 32'd0);
        @(posedge clk50m);
        #1;
        reset_n = 1'b1;
        exp_fc = '0;
        step();
        chk("t7_q_empty", 32'(exp_q.size()), 32'd0);

        // T5: continuous mode, frame counter through wrap, overflow cleared on re-arm
        cont = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int f = 0; f < 256; f++) begin
            run_frame(12'(f * 8), (f == 0) ? 6 : 99, (f == 0) ? 6 : 99, 1'b0);
            exp_fc = exp_fc + 8'd1;
            chk("t5_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
            if (f == 0) chk("t5_overflow_set", 32'(overflow), 32'd1);
            fifo_empty = 1'b1;
            step();
            fifo_empty = 1'b0;
            chk("t5_state_holdoff", 32'(state_o), 32'd4);
            repeat (HC) step();
            chk("t5_rearm", 32'(state_o), 32'd1);
            chk("t5_overflow_cleared", 32'(overflow), 32'd0);
        end
        chk("t5_wrapped", 32'(frame_cnt), 32'd0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("t5_stop_idle", 32'(busy), 32'd0);
        repeat (4) step();
        chk("t5_q_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/adc_capture_sched.md
Name: adc_capture_sched

Overview:
- Sequences the 12-bit AD capture path into the sample FIFO as triggered, fixed-length frames, oscilloscope style.
- Sits between the AD capture block output (12-bit, one sample per clk50m) and the FIFO write port; the UART side drains the FIFO independently.
- Provides decimation, edge/auto trigger with timeout, per-word framing tags, overflow accounting and single/continuous modes.

Parameters:
- FRAME_LEN, 256, samples per frame (2..65535)
- ARM_TIMEOUT, 65535, decimated ticks in ARM before a forced trigger (>=1)
- HOLDOFF_CYC, 1000, clk50m cycles idle between frames in continuous mode (>=1)

Ports:
- clk50m  in  1  system clock, 50 MHz, sole clock
- reset_n  in  1  asynchronous active-low reset
- ad_ch1  in  12  AD sample, valid every cycle
- start  in  1  one-cycle pulse: begin capture
- stop  in  1  one-cycle pulse: abort to IDLE
- cont  in  1  1 = re-arm after each frame, 0 = single frame
- trig_mode  in  1  0 = immediate, 1 = rising-edge level trigger
- trig_level  in  12  trigger threshold, unsigned
- div_sel  in  16  decimation: one tick every div_sel+1 cycles
- fifo_full  in  1  FIFO full flag, write-side clock
- fifo_empty  in  1  FIFO empty flag, synchronised to clk50m
- wr_en  out  1  FIFO write strobe
- wr_data  out  16  tagged sample word
- busy  out  1  state != IDLE
- overflow  out  1  sticky: a sample was dropped this frame
- frame_cnt  out  8  completed-frame counter
- state_o  out  3  current state, for debug

Behaviour:
- Reset (async, reset_n=0): state IDLE; wr_en=0, wr_data=0, busy=0, overflow=0, frame_cnt=0; all counters 0.
- Config latch: div_sel, trig_mode, trig_level and cont are captured on an accepted start. Changes mid-frame are ignored.
- Tick: the decimation counter counts 0..div_sel_latched. tick=1 when count==div_sel_latched, then wraps to 0. div_sel=0 gives a tick every cycle. The counter clears on entry to ARM.
- States: IDLE=0, ARM=1, CAPTURE=2, DRAIN=3, HOLDOFF=4.
- IDLE:
  - start -> ARM; clears overflow, the sample counter and the timeout counter.
  - start while busy is ignored.
- ARM: on each tick, register the sample as prev.
  - trig_mode=0: the first tick triggers.
  - trig_mode=1: triggers when prev<trig_level and cur>=trig_level. The first tick after entering ARM only loads prev and cannot trigger.
  - If ARM_TIMEOUT ticks pass without a trigger, the next tick triggers with forced=1.
  - On trigger -> CAPTURE. The triggering sample is frame sample 0 and is written.
- CAPTURE: each tick emits sample n, n=0..FRAME_LEN-1.
  - fifo_full=1 at a tick: the sample is dropped (no wr_en), overflow is set, n still advances. The frame stays time-correct.
  - After sample FRAME_LEN-1 is emitted or dropped -> DRAIN.
- DRAIN:
  - frame_cnt increments (mod 256) on entry.
  - Waits for fifo_empty=1 -> HOLDOFF.
- HOLDOFF:
  - Counts HOLDOFF_CYC cycles.
  - Then cont=1 -> ARM (overflow cleared, counters reset); cont=0 -> IDLE.
- stop in any non-IDLE state:
  - Next state is IDLE; wr_en=0 next cycle; no further words.
  - frame_cnt is unchanged if stop arrives before DRAIN.
  - stop takes priority over start and over a same-cycle trigger.
- wr_data word:
  - [15] SOF = sample 0
  - [14] EOF = sample FRAME_LEN-1
  - [13] forced trigger
  - [12] overflow-so-far
  - [11:0] sample
- Latency: the sample present on ad_ch1 in the tick cycle appears on wr_data with wr_en=1 exactly one cycle later. wr_en is a single-cycle pulse per tick.
- A dropped SOF or EOF word is not re-sent. Overflow in later words (or the status output) reports the loss.

Decomposition:
- Shared package adc_sched_pkg:
  - state encoding constants (IDLE..HOLDOFF)
  - tag bit positions SOF_BIT=15, EOF_BIT=14, FORCED_BIT=13, OVF_BIT=12
  - SAMPLE_W=12, WORD_W=16
- One natural sub-module: adc_tick_gen (decimation counter with clear input and tick output).
- FSM, counters and output register stay in the top.

Test Plan:
- div_sel=0, trig_mode=0, FRAME_LEN=8, fifo_full=0, pulse start -> 8 consecutive wr_en pulses, the first beginning 2 cycles after start; SOF only on word 0, EOF only on word 7; frame_cnt 0->1; busy falls after fifo_empty plus HOLDOFF_CYC.
- trig_mode=1, trig_level=0x800, ramp ad_ch1 0x7FC,0x7FE,0x800,0x802 with div_sel=0 -> first written word = 0x800 with SOF=1; no writes before it.
- trig_mode=1, ad_ch1 constant 0x100, ARM_TIMEOUT=4, div_sel=3 -> forced trigger on the 5th tick (cycle ~20); every word has bit13=1.
- fifo_full=1 during samples 3..4 of an 8-sample frame -> 6 writes; the 6 written words carry samples 0,1,2,5,6,7; overflow=1; words 5..7 have bit12=1.
- cont=1, fifo_empty pulsed after each frame -> frame_cnt counts 1,2,3; overflow cleared at each re-arm; frame_cnt wraps 255->0.
- Reset/abort: stop during CAPTURE at sample 4 -> IDLE next cycle, no further wr_en, frame_cnt unchanged. reset_n low mid-frame -> all outputs 0 immediately, with no clock edge required.
